ex_stage: RTL and testbench

Execute stage of the 5-stage RISC-V pipeline, sitting directly downstream of the fetch/decode pair. It accepts decoded instructions from decode over a valid/allow_in handshake and holds them in the DS→EX pipeline register. It computes the ALU result, resolves branches and jumps, and returns the 33-bit `branch_data` redirect to fetch. Results go to the memory stage over a second valid/allow_in handshake.

---
 rtl/ex_stage_pkg.sv | 57 +++++
 rtl/ex_alu.sv | 32 +++
 rtl/ex_stage.sv | 98 +++++++++
 tb/tb_ex_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared encodings and bus layouts for the execute stage.
// Decode and memory stages use the same definitions.
package ex_stage_pkg;

  localparam int unsigned DsExWidth  = 149;
  localparam int unsigned ExMemWidth = 107;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPass2 = 4'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    BrNone = 4'd0,
    BrJal  = 4'd1,
    BrJalr = 4'd2,
    BrBeq  = 4'd3,
    BrBne  = 4'd4,
    BrBlt  = 4'd5,
    BrBge  = 4'd6,
    BrBltu = 4'd7,
    BrBgeu = 4'd8
  } br_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    br_op_e      br_op;
    logic        src1_pc;
    logic        src2_imm;
    logic        rf_we;
    logic [4:0]  mem_ctl;
  } ds_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        rf_we;
    logic [4:0]  mem_ctl;
  } ex_mem_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU for the execute stage.
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  alu_op_e     i_alu_op,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_op2[4:0];

  always_comb begin
    o_result = '0;
    case (i_alu_op)
      AluAdd:   o_result = i_op1 + i_op2;
      AluSub:   o_result = i_op1 - i_op2;
      AluSll:   o_result = i_op1 << w_shamt;
      AluSlt:   o_result = {31'b0, $signed(i_op1) < $signed(i_op2)};
      AluSltu:  o_result = {31'b0, i_op1 < i_op2};
      AluXor:   o_result = i_op1 ^ i_op2;
      AluSrl:   o_result = i_op1 >> w_shamt;
      AluSra:   o_result = $unsigned($signed(i_op1) >>> w_shamt);
      AluOr:    o_result = i_op1 | i_op2;
      AluAnd:   o_result = i_op1 & i_op2;
      AluPass2: o_result = i_op2;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: DS->EX pipeline register, ALU, branch resolution and
// fetch redirect, with valid/allow_in handshakes on both sides.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DS_EX_W  = DsExWidth,
  parameter int unsigned EX_MEM_W = ExMemWidth
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_to_ex_valid,
  input  logic [DS_EX_W-1:0]  ds_ex_reg_data,
  output logic                ds_ex_reg_allow_in,
  output logic [32:0]         branch_data,
  output logic                ex_to_mem_valid,
  output logic [EX_MEM_W-1:0] ex_mem_reg_data,
  input  logic                mem_allow_in,
  output logic [37:0]         ex_fwd
);

  logic        r_ex_valid;
  ds_ex_t      r_ds;

  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_alu_out;
  logic [31:0] w_alu_result;
  logic [31:0] w_target;
  logic        w_is_jump;
  logic        w_taken;
  logic        w_fire;
  logic        w_allow_in;
  ex_mem_t     w_out;

  assign w_op1 = r_ds.src1_pc  ? r_ds.pc  : r_ds.rs1_val;
  assign w_op2 = r_ds.src2_imm ? r_ds.imm : r_ds.rs2_val;

  ex_alu u_alu (
    .i_op1    (w_op1),
    .i_op2    (w_op2),
    .i_alu_op (r_ds.alu_op),
    .o_result (w_alu_out)
  );

  always_comb begin
    w_taken = 1'b0;
    case (r_ds.br_op)
      BrJal:   w_taken = 1'b1;
      BrJalr:  w_taken = 1'b1;
      BrBeq:   w_taken = r_ds.rs1_val == r_ds.rs2_val;
      BrBne:   w_taken = r_ds.rs1_val != r_ds.rs2_val;
      BrBlt:   w_taken = $signed(r_ds.rs1_val) < $signed(r_ds.rs2_val);
      BrBge:   w_taken = $signed(r_ds.rs1_val) >= $signed(r_ds.rs2_val);
      BrBltu:  w_taken = r_ds.rs1_val < r_ds.rs2_val;
      BrBgeu:  w_taken = r_ds.rs1_val >= r_ds.rs2_val;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_is_jump    = (r_ds.br_op == BrJal) || (r_ds.br_op == BrJalr);
  assign w_alu_result = w_is_jump ? r_ds.pc + 32'd4 : w_alu_out;
  assign w_target     = (r_ds.br_op == BrJalr) ? ((r_ds.rs1_val + r_ds.imm) & ~32'd1)
                                               : r_ds.pc + r_ds.imm;

  // Redirect only in the cycle the branch leaves EX, so a stall cannot repeat it.
  assign w_fire     = r_ex_valid & w_taken & mem_allow_in;
  assign w_allow_in = ~r_ex_valid | mem_allow_in;

  assign ds_ex_reg_allow_in = w_allow_in;
  assign ex_to_mem_valid    = r_ex_valid;
  assign branch_data        = {w_fire, w_fire ? w_target : 32'd0};
  assign ex_fwd             = {r_ex_valid & r_ds.rf_we, r_ds.rd, w_alu_result};

  always_comb begin
    w_out            = '0;
    w_out.pc         = r_ds.pc;
    w_out.alu_result = w_alu_result;
    w_out.store_data = r_ds.rs2_val;
    w_out.rd         = r_ds.rd;
    w_out.rf_we      = r_ds.rf_we;
    w_out.mem_ctl    = r_ds.mem_ctl;
  end
  assign ex_mem_reg_data = w_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ds       <= '0;
    end else if (w_allow_in) begin
      // A fetch redirect this cycle makes the offered instruction wrong-path.
      r_ex_valid <= ds_to_ex_valid & ~w_fire;
      if (ds_to_ex_valid) begin
        r_ds <= ds_ex_reg_data;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ds_to_ex_valid;
  logic [148:0] ds_ex_reg_data;
  logic         ds_ex_reg_allow_in;
  logic [32:0]  branch_data;
  logic         ex_to_mem_valid;
  logic [106:0] ex_mem_reg_data;
  logic         mem_allow_in;
  logic [37:0]  ex_fwd;

  int n_vec = 0;
  int n_err = 0;

  wire [31:0] pc_o    = ex_mem_reg_data[106:75];
  wire [31:0] alu_o   = ex_mem_reg_data[74:43];
  wire [31:0] store_o = ex_mem_reg_data[42:11];
  wire [4:0]  rd_o    = ex_mem_reg_data[10:6];
  wire        we_o    = ex_mem_reg_data[5];
  wire [4:0]  mc_o    = ex_mem_reg_data[4:0];

  ex_stage dut (
    .clk                (clk),
    .reset              (reset),
    .ds_to_ex_valid     (ds_to_ex_valid),
    .ds_ex_reg_data     (ds_ex_reg_data),
    .ds_ex_reg_allow_in (ds_ex_reg_allow_in),
    .branch_data        (branch_data),
    .ex_to_mem_valid    (ex_to_mem_valid),
    .ex_mem_reg_data    (ex_mem_reg_data),
    .mem_allow_in       (mem_allow_in),
    .ex_fwd             (ex_fwd)
  );

  always #5 clk = ~clk;

  function automatic logic [148:0] mk(input logic [31:0] pc, input logic [31:0] rs1,
                                      input logic [31:0] rs2, input logic [31:0] imm,
                                      input logic [4:0] rd, input logic [3:0] alu,
                                      input logic [3:0] br, input logic s1pc,
                                      input logic s2imm, input logic we,
                                      input logic [4:0] mc);
    return {pc, rs1, rs2, imm, rd, alu, br, s1pc, s2imm, we, mc};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ds_to_ex_valid = 1'b0;
    ds_ex_reg_data = '0;
    mem_allow_in = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (ex_to_mem_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %b want 0", ex_to_mem_valid); end
    n_vec++; if (branch_data !== 33'h0) begin
      n_err++; $display("FAIL reset_branch got %h want 0", branch_data); end
    n_vec++; if (ds_ex_reg_allow_in !== 1'b1) begin
      n_err++; $display("FAIL reset_allow got %b want 1", ds_ex_reg_allow_in); end
    n_vec++; if (ex_fwd !== 38'h0) begin
      n_err++; $display("FAIL reset_fwd got %h want 0", ex_fwd); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    mem_allow_in = 1'b1;
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h100, 32'd5, 32'd7, 32'd0, 5'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 5'h15);
    @(negedge clk);
    ds_ex_reg_data = mk(32'h104, 32'h8000_0000, 32'd0, 32'd4, 5'd4, 4'd7, 4'd0, 1'b0, 1'b1,
                        1'b1, 5'h0);
    n_vec++; if (ex_to_mem_valid !== 1'b1) begin
      n_err++; $display("FAIL add_valid got %b want 1", ex_to_mem_valid); end
    n_vec++; if (alu_o !== 32'd12) begin
      n_err++; $display("FAIL add_result got %h want %h", alu_o, 32'd12); end
    n_vec++; if (ex_fwd !== {1'b1, 5'd3, 32'd12}) begin
      n_err++; $display("FAIL add_fwd got %h want %h", ex_fwd, {1'b1, 5'd3, 32'd12}); end
    n_vec++; if ({pc_o, store_o, rd_o, we_o, mc_o} !== {32'h100, 32'd7, 5'd3, 1'b1, 5'h15}) begin
      n_err++; $display("FAIL add_fields got %h/%h/%h/%b/%h want 100/7/3/1/15",
                        pc_o, store_o, rd_o, we_o, mc_o); end
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    n_vec++; if (alu_o !== 32'hF800_0000) begin
      n_err++; $display("FAIL sra_result got %h want f8000000", alu_o); end
    @(negedge clk);
    n_vec++; if (ex_to_mem_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_valid got %b want 0", ex_to_mem_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    mem_allow_in = 1'b1;
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h400, 32'd1, 32'd2, 32'd0, 5'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 5'h0);
    @(negedge clk);
    ds_ex_reg_data = mk(32'h404, 32'hF0, 32'hFF, 32'd0, 5'd2, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 5'h0);
    mem_allow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if ({ds_ex_reg_allow_in, ex_to_mem_valid, alu_o} !== {1'b0, 1'b1, 32'd3}) begin
        n_err++; $display("FAIL stall_hold cyc%0d got allow=%b v=%b r=%h want 0/1/3",
                          i, ds_ex_reg_allow_in, ex_to_mem_valid, alu_o); end
      @(negedge clk);
    end
    mem_allow_in = 1'b1;
    #1;
    n_vec++; if (ds_ex_reg_allow_in !== 1'b1) begin
      n_err++; $display("FAIL release_allow got %b want 1", ds_ex_reg_allow_in); end
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    n_vec++; if ({ex_to_mem_valid, alu_o, rd_o} !== {1'b1, 32'h0F, 5'd2}) begin
      n_err++; $display("FAIL second_deliver got v=%b r=%h rd=%0d want 1/f/2",
                        ex_to_mem_valid, alu_o, rd_o); end
    @(negedge clk);
    n_vec++; if (ex_to_mem_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain got %b want 0", ex_to_mem_valid); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    mem_allow_in = 1'b1;
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h200, 32'd9, 32'd9, 32'h40, 5'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 5'h0);
    @(negedge clk);
    ds_ex_reg_data = mk(32'h204, 32'd1, 32'd1, 32'd0, 5'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 5'h0);
    n_vec++; if (branch_data !== {1'b1, 32'h240}) begin
      n_err++; $display("FAIL beq_redirect got %h want 1_00000240", branch_data); end
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    n_vec++; if ({ex_to_mem_valid, branch_data} !== 34'h0) begin
      n_err++; $display("FAIL beq_flush got v=%b bd=%h want 0/0", ex_to_mem_valid, branch_data);
    end
    @(negedge clk);
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h200, 32'd9, 32'd9, 32'h40, 5'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 5'h0);
    @(negedge clk);
    ds_ex_reg_data = mk(32'h208, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 4'd0, 4'd5, 1'b0, 1'b0,
                        1'b0, 5'h0);
    n_vec++; if ({ex_to_mem_valid, branch_data} !== {1'b1, 33'h0}) begin
      n_err++; $display("FAIL bne_equal got v=%b bd=%h want 1/0", ex_to_mem_valid, branch_data);
    end
    @(negedge clk);
    ds_ex_reg_data = mk(32'h20C, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 4'd0, 4'd7, 1'b0, 1'b0,
                        1'b0, 5'h0);
    n_vec++; if (branch_data !== {1'b1, 32'h218}) begin
      n_err++; $display("FAIL blt_signed got %h want 1_00000218", branch_data); end
    @(negedge clk);
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h20C, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 4'd0, 4'd7, 1'b0, 1'b0,
                        1'b0, 5'h0);
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    n_vec++; if ({ex_to_mem_valid, branch_data} !== {1'b1, 33'h0}) begin
      n_err++; $display("FAIL bltu_not_taken got v=%b bd=%h want 1/0",
                        ex_to_mem_valid, branch_data); end
    @(negedge clk);
  endtask

  task automatic test_jalr();
    @(negedge clk);
    mem_allow_in = 1'b1;
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h300, 32'h1001, 32'd0, 32'd4, 5'd1, 4'd5, 4'd2, 1'b0, 1'b1, 1'b1, 5'h0);
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    n_vec++; if ({branch_data, alu_o} !== {1'b1, 32'h1004, 32'h304}) begin
      n_err++; $display("FAIL jalr got bd=%h r=%h want 1_00001004/304", branch_data, alu_o); end
    @(negedge clk);
    ds_to_ex_valid = 1'b1;
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    mem_allow_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if ({ex_to_mem_valid, branch_data} !== {1'b1, 33'h0}) begin
        n_err++; $display("FAIL jalr_stall cyc%0d got v=%b bd=%h want 1/0",
                          i, ex_to_mem_valid, branch_data); end
      @(negedge clk);
    end
    mem_allow_in = 1'b1;
    #1;
    n_vec++; if (branch_data !== {1'b1, 32'h1004}) begin
      n_err++; $display("FAIL jalr_release got %h want 1_00001004", branch_data); end
    @(negedge clk);
    n_vec++; if ({ex_to_mem_valid, branch_data} !== 34'h0) begin
      n_err++; $display("FAIL jalr_single got v=%b bd=%h want 0/0", ex_to_mem_valid, branch_data);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    mem_allow_in = 1'b1;
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h500, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd6, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1,
                        5'h0);
    @(negedge clk);
    ds_ex_reg_data = mk(32'hFFFF_FFF0, 32'd3, 32'd3, 32'h20, 5'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0,
                        5'h0);
    n_vec++; if ({ex_to_mem_valid, alu_o} !== {1'b1, 32'd0}) begin
      n_err++; $display("FAIL add_wrap got v=%b r=%h want 1/0", ex_to_mem_valid, alu_o); end
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    n_vec++; if (branch_data !== {1'b1, 32'h10}) begin
      n_err++; $display("FAIL target_wrap got %h want 1_00000010", branch_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_allow_in = 1'b1;
    ds_to_ex_valid = 1'b1;
    ds_ex_reg_data = mk(32'h600, 32'd2, 32'd2, 32'h8, 5'd9, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 5'h0);
    @(negedge clk);
    ds_to_ex_valid = 1'b0;
    mem_allow_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_vec++; if ({ex_to_mem_valid, branch_data, ex_fwd, ds_ex_reg_allow_in} !== {72'h0, 1'b1})
    begin
      n_err++; $display("FAIL reset_async got v=%b bd=%h fwd=%h allow=%b want 0/0/0/1",
                        ex_to_mem_valid, branch_data, ex_fwd, ds_ex_reg_allow_in); end
    #1 reset = 1'b0;
    mem_allow_in = 1'b1;
    @(negedge clk);
    n_vec++; if ({ex_to_mem_valid, branch_data} !== 34'h0) begin
      n_err++; $display("FAIL reset_no_replay got v=%b bd=%h want 0/0",
                        ex_to_mem_valid, branch_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_backpressure();
    test_branch();
    test_jalr();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
